snax_gemm_result_serializer: RTL and testbench
==============================================

# snax_gemm_result_serializer

Output-side width converter placed directly downstream of the GEMM accelerator's result port. It accepts one wide result word per handshake from the GEMM and emits it to the write streamer as a sequence of narrower beats, least-significant slice first. Back-to-back throughput carries no bubbles, and a readable beat counter supports performance monitoring through the CSR read-only set.

## Interface
Parameters:
- InWidth, 2048, width of a GEMM result word; must be an integer multiple of OutWidth.
- OutWidth, 512, width of one beat toward the streamer.
- CntWidth, 32, width of the beat counter, equal to the CSR register data width.

Ports:
- clk_i  input  1  single clock; all state is rising-edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- gemm_c_data_i  input  InWidth  result word from the GEMM.
- gemm_c_valid_i  input  1  result word valid.
- gemm_c_ready_o  output  1  serializer can accept a result word.
- acc2stream_0_data_o  output  OutWidth  beat toward the streamer.
- acc2stream_0_valid_o  output  1  beat valid.
- acc2stream_0_ready_i  input  1  streamer accepts the beat.
- clear_i  input  1  synchronous flush; drops held data and resets the counter.
- busy_o  output  1  a word is held or partially sent.
- beat_count_o  output  CntWidth  number of completed output beats since reset or clear.

## Operation
- Ratio R = InWidth/OutWidth; beat index width = max(1, clog2(R)).
- Holding register: `hold_q` [InWidth], `full_q`, beat index `idx_q`.
- States:
  - EMPTY: `full_q=0`.
  - SEND: `full_q=1`; output data is slice `idx_q` of `hold_q`, i.e. bits [`idx_q`*OutWidth +: OutWidth].
- `gemm_c_ready_o = !full_q || (acc2stream_0_ready_i && idx_q==R-1)`. Ready is combinationally dependent on `acc2stream_0_ready_i`; this is the only combinational path.
- `acc2stream_0_valid_o = full_q`; `busy_o = full_q`.
- Input handshake (`gemm_c_valid_i && gemm_c_ready_o`):
  - loads `hold_q`, sets `full_q=1`, sets `idx_q=0`.
  - If it coincides with the last-beat handshake, the new word replaces the old one and SEND continues.
- Output handshake:
  - Increments `beat_count_o`, which wraps modulo 2^CntWidth.
  - If `idx_q<R-1`, `idx_q++`.
  - Otherwise, with no simultaneous input handshake, `full_q` clears and the state returns to EMPTY.
- R=1 degenerates to a one-entry pipeline register with full throughput.
- Data is never altered and slice order is fixed at LSB first.
- clear_i takes priority over both handshakes in the same cycle:
  - `full_q=0`, `idx_q=0`, counter=0.
  - A simultaneous input handshake is discarded. Ready still reflects the pre-clear state; upstream has to account for this.

## Timing
- Reset values:
  - `full_q=0`, `idx_q=0`, counter=0.
  - `gemm_c_ready_o=1`, `acc2stream_0_valid_o=0`, `busy_o=0`, `beat_count_o=0`.
  - `acc2stream_0_data_o` is slice 0 of a zeroed `hold_q`, so all zeros.
- Latency: a word accepted in cycle t presents beat 0 in cycle t+1.
- Throughput: with the streamer always ready, one beat per cycle, and a new word every R cycles with no idle cycle between words.
- Valid and data must stay stable while valid && !ready. They are held until handshake.
- Asserting reset mid-word discards the word immediately, without waiting for a clock edge.
- `beat_count_o` updates the cycle after the handshake.

## Structure
- Shared package `snax_gemm_pkg` holds:
  - the default widths (2048/512/32);
  - the derived constant R;
  - the beat index width.
- No sub-module. The datapath is one register, one mux and one counter.
- An elaboration-time assertion checks `InWidth % OutWidth == 0`.

## Test plan
- **Single word, R=4, streamer always ready:** load word whose four 512-bit slices hold 0xA..., 0xB..., 0xC..., 0xD...
  - Beats appear in cycles t+1..t+4 in order A, B, C, D.
  - `beat_count_o=4`; `busy_o` drops after the 4th beat.
- **Back-to-back:** three words with continuous valid, streamer always ready.
  - 12 consecutive beats with no gap.
  - `gemm_c_ready_o` pulses high exactly on each last-beat cycle.
- **Backpressure:** drop `acc2stream_0_ready_i` for 5 cycles at beat 2.
  - Beat 2 data and valid stay stable throughout.
  - `gemm_c_ready_o` stays 0.
  - The sequence resumes with beat 2 and no loss or duplication.
- **Clear mid-word:** pulse `clear_i` after beat 1.
  - Next cycle: valid=0, `busy_o=0`, `beat_count_o=0`.
  - The next word starts at slice 0.
- **Async reset mid-word:** deassert `rst_ni` between clock edges during beat 2.
  - Outputs go to their reset values immediately.
  - After release, a fresh word serializes correctly.
- **Counter wrap:** preload the counter to 2^32-2 (force in the bench), then send 4 beats.
  - `beat_count_o` reads 2.

Source files
------------

// File: rtl/snax_gemm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snax_gemm_pkg
// Description : Shared widths and derived constants for the GEMM result
//               path. Default result word width, default beat width, CSR
//               data width, the serialization ratio and the beat index
//               width derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
package snax_gemm_pkg;

    localparam int DEF_IN_WIDTH  = 2048;
    localparam int DEF_OUT_WIDTH = 512;
    localparam int DEF_CNT_WIDTH = 32;

    // Number of beats per result word for the default widths.
    localparam int GEMM_RATIO = DEF_IN_WIDTH / DEF_OUT_WIDTH;

    // A beat index needs at least one bit even when the ratio is 1.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int GEMM_IDX_WIDTH = idx_width(GEMM_RATIO);

endpackage : snax_gemm_pkg
`default_nettype wire

// File: rtl/snax_gemm_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : snax_gemm_result_serializer
// Description : Wide-to-narrow width converter between the GEMM result port
//               and the write streamer. One IN_WIDTH word is taken per input
//               handshake and emitted as IN_WIDTH/OUT_WIDTH beats, least
//               significant slice first, with no bubbles between words.
//               A free-running beat counter is exposed for CSR read-back.
// Ports       : clk_i, rst_ni            - clock, async active-low reset
//               gemm_c_*                 - result word in (valid/ready)
//               acc2stream_0_*           - beats out (valid/ready)
//               clear_i                  - synchronous flush + counter clear
//               busy_o                   - a word is held / partially sent
//               beat_count_o             - completed output beats
// Revision    : 1.0 - initial release
// ============================================================================
module snax_gemm_result_serializer
    import snax_gemm_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IN_WIDTH-1:0]  gemm_c_data_i,
    input  logic                 gemm_c_valid_i,
    output logic                 gemm_c_ready_o,
    output logic [OUT_WIDTH-1:0] acc2stream_0_data_o,
    output logic                 acc2stream_0_valid_o,
    input  logic                 acc2stream_0_ready_i,
    input  logic                 clear_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] beat_count_o
);

    localparam int c_RATIO     = IN_WIDTH / OUT_WIDTH;
    localparam int c_IDX_WIDTH = idx_width(c_RATIO);
    localparam logic [c_IDX_WIDTH-1:0] c_LAST_IDX = c_IDX_WIDTH'(c_RATIO - 1);

    generate
        if (IN_WIDTH % OUT_WIDTH != 0) begin : g_width_check
            $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
        end
    endgenerate

    logic [IN_WIDTH-1:0]    r_hold;
    logic                   r_full;
    logic [c_IDX_WIDTH-1:0] r_idx;
    logic [CNT_WIDTH-1:0]   r_beat_count;

    logic                   w_last;
    logic                   w_in_hs;
    logic                   w_out_hs;

    // Slice view of the holding register for the output mux.
    logic [c_RATIO-1:0][OUT_WIDTH-1:0] w_slices;

    assign w_slices = r_hold;
    assign w_last   = (r_idx == c_LAST_IDX);

    // The only combinational input-to-output path: a new word may be taken
    // in the same cycle the last beat of the current word leaves.
    assign gemm_c_ready_o = !r_full || (acc2stream_0_ready_i && w_last);

    assign w_in_hs  = gemm_c_valid_i && gemm_c_ready_o;
    assign w_out_hs = r_full && acc2stream_0_ready_i;

    assign acc2stream_0_data_o  = w_slices[r_idx];
    assign acc2stream_0_valid_o = r_full;
    assign busy_o               = r_full;
    assign beat_count_o         = r_beat_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold       <= '0;
            r_full       <= 1'b0;
            r_idx        <= '0;
            r_beat_count <= '0;
        end else if (clear_i) begin
            // Flush wins over both handshakes; the held data itself is
            // left in place since it is no longer marked valid.
            r_full       <= 1'b0;
            r_idx        <= '0;
            r_beat_count <= '0;
        end else begin
            if (w_out_hs) begin
                r_beat_count <= r_beat_count + CNT_WIDTH'(1);
            end
            if (w_in_hs) begin
                // Also covers the overlap with the last beat: the new word
                // replaces the old one and sending continues at slice 0.
                r_hold <= gemm_c_data_i;
                r_full <= 1'b1;
                r_idx  <= '0;
            end else if (w_out_hs) begin
                if (!w_last) begin
                    r_idx <= r_idx + c_IDX_WIDTH'(1);
                end else begin
                    r_full <= 1'b0;
                end
            end
        end
    end

endmodule : snax_gemm_result_serializer
`default_nettype wire

// File: tb/tb_snax_gemm_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_snax_gemm_result_serializer
// Description : Directed and randomized bench for the result serializer,
//               checked against a queue-of-beats reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snax_gemm_result_serializer;

    localparam int IW = 2048;
    localparam int OW = 512;
    localparam int CW = 32;
    localparam int R  = IW / OW;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [IW-1:0] gemm_c_data_i;
    logic          gemm_c_valid_i;
    logic          gemm_c_ready_o;
    logic [OW-1:0] acc2stream_0_data_o;
    logic          acc2stream_0_valid_o;
    logic          acc2stream_0_ready_i;
    logic          clear_i;
    logic          busy_o;
    logic [CW-1:0] beat_count_o;

    snax_gemm_result_serializer dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .gemm_c_data_i        (gemm_c_data_i),
        .gemm_c_valid_i       (gemm_c_valid_i),
        .gemm_c_ready_o       (gemm_c_ready_o),
        .acc2stream_0_data_o  (acc2stream_0_data_o),
        .acc2stream_0_valid_o (acc2stream_0_valid_o),
        .acc2stream_0_ready_i (acc2stream_0_ready_i),
        .clear_i              (clear_i),
        .busy_o               (busy_o),
        .beat_count_o         (beat_count_o)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: beats still owed for the word in flight, and the
    // number of beats delivered since reset/clear.
    logic [OW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt;
    bit            last_acc;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_model(input logic [IW-1:0] w);
        exp_q.delete();
        for (int k = 0; k < R; k++) exp_q.push_back(w[k*OW +: OW]);
    endtask

    function automatic logic [IW-1:0] rand_word();
        logic [IW-1:0] w;
        for (int k = 0; k < IW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Check one cycle's outputs against the model, then advance the model
    // by whatever handshakes happen at the coming edge.
    task automatic tick();
        bit ev, er, in_hs, out_hs;
        #1;
        ev = (exp_q.size() != 0);
        er = !ev || (exp_q.size() == 1 && acc2stream_0_ready_i);
        chk("valid", OW'(acc2stream_0_valid_o), OW'(ev));
        chk("busy",  OW'(busy_o), OW'(ev));
        chk("ready", OW'(gemm_c_ready_o), OW'(er));
        chk("count", OW'(beat_count_o), OW'(exp_cnt));
        if (ev) chk("data", acc2stream_0_data_o, exp_q[0]);
        in_hs    = gemm_c_valid_i && er;
        out_hs   = ev && acc2stream_0_ready_i;
        last_acc = in_hs && !clear_i;
        if (clear_i) begin
            exp_q.delete();
            exp_cnt = '0;
        end else begin
            if (out_hs) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 1;
            end
            if (in_hs) load_model(gemm_c_data_i);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_word(input logic [IW-1:0] w);
        bit done = 0;
        gemm_c_valid_i = 1'b1;
        gemm_c_data_i  = w;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = last_acc;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $error("FAIL accept_timeout observed=0 expected=1");
        end
        gemm_c_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, OW'(acc2stream_0_valid_o), '0);
        chk({tag, "_busy"},  OW'(busy_o), '0);
        chk({tag, "_ready"}, OW'(gemm_c_ready_o), OW'(1));
        chk({tag, "_count"}, OW'(beat_count_o), '0);
        chk({tag, "_data"},  acc2stream_0_data_o, '0);
    endtask

    initial begin
        logic [IW-1:0] pat;
        logic [3:0]    nib;

        rst_ni               = 1'b0;
        gemm_c_data_i        = '0;
        gemm_c_valid_i       = 1'b0;
        acc2stream_0_ready_i = 1'b1;
        clear_i              = 1'b0;
        exp_cnt              = '0;

        // Reset state
        #2;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        tick();

        // Single word, slices A/B/C/D, streamer always ready
        for (int k = 0; k < R; k++) begin
            nib = 4'hA + 4'(k);
            pat[k*OW +: OW] = {128{nib}};
        end
        send_word(pat);
        for (int k = 0; k < R; k++) begin
            nib = 4'hA + 4'(k);
            chk("pattern_beat", acc2stream_0_data_o, {128{nib}});
            tick();
        end
        chk("single_count", OW'(beat_count_o), OW'(4));
        chk("single_busy_low", OW'(busy_o), '0);
        tick();

        // Back-to-back words with continuous valid
        send_word(rand_word());
        send_word(rand_word());
        send_word(rand_word());
        repeat (R + 1) tick();
        chk("b2b_count", OW'(beat_count_o), OW'(16));

        // Backpressure at beat 2 with a pending upstream word
        send_word(rand_word());
        tick();
        tick();
        acc2stream_0_ready_i = 1'b0;
        gemm_c_valid_i       = 1'b1;
        gemm_c_data_i        = rand_word();
        repeat (5) tick();
        gemm_c_valid_i       = 1'b0;
        acc2stream_0_ready_i = 1'b1;
        repeat (R) tick();

        // Clear after beat 1
        send_word(rand_word());
        tick();
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clear_count", OW'(beat_count_o), '0);
        chk("clear_valid", OW'(acc2stream_0_valid_o), '0);
        tick();
        send_word(rand_word());
        repeat (R + 1) tick();

        // Asynchronous reset during beat 2
        send_word(rand_word());
        tick();
        tick();
        #3;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        exp_cnt = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        send_word(rand_word());
        repeat (R + 1) tick();

        // Counter wrap from 2^32-2
        force dut.r_beat_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_beat_count;
        exp_cnt = 32'hFFFF_FFFE;
        send_word(rand_word());
        repeat (R) tick();
        chk("wrap_count", OW'(beat_count_o), OW'(2));
        tick();

        // Randomized traffic with occasional flushes
        for (int n = 0; n < 400; n++) begin
            if (!gemm_c_valid_i || last_acc || $urandom_range(0, 3) == 0)
                gemm_c_data_i = rand_word();
            gemm_c_valid_i       = ($urandom_range(0, 2) != 0);
            acc2stream_0_ready_i = ($urandom_range(0, 3) != 0);
            clear_i              = ($urandom_range(0, 39) == 0);
            tick();
        end
        gemm_c_valid_i       = 1'b0;
        clear_i              = 1'b0;
        acc2stream_0_ready_i = 1'b1;
        repeat (R + 1) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_snax_gemm_result_serializer
`default_nettype wire
